// File: rtl/alu_writeback_pkg.sv
// -----------------------------------------------------------------------------
// alu_writeback_pkg
// Shared definitions for the ALU execute/writeback stage:
//   DATA_W        datapath width (accumulator, results, register data)
//   slot_state_e  one-entry write slot FSM encoding (SLOT_EMPTY / SLOT_FULL)
//   fwd_select()  read-data forwarding mux helper
// -----------------------------------------------------------------------------
package alu_writeback_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Picks the in-flight slot data over the raw register-file data on a hit.
  function automatic logic [DATA_W-1:0] fwd_select(
    input logic              use_slot,
    input logic [DATA_W-1:0] slot_data,
    input logic [DATA_W-1:0] rf_data
  );
    logic [DATA_W-1:0] res;
    if (use_slot) begin
      res = slot_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// -----------------------------------------------------------------------------
// alu_writeback_if
// Bundles the ALU-result handshake (ex_*) and the register-file write port
// (rf_*) seen by the writeback stage.
//   master : the environment (ALU + register file) side
//   slave  : the writeback stage side
// Parameter: ADDR_W register-file address width.
// -----------------------------------------------------------------------------
interface alu_writeback_if
  import alu_writeback_pkg::*;
#(
  parameter int ADDR_W = 8
);

  // ALU result handshake
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_result;
  logic              ex_accum_write;
  logic              ex_reg_write;
  logic [ADDR_W-1:0] ex_reg_addr;
  logic              ex_z_write;
  logic              ex_zout;
  logic              ex_c_write;
  logic              ex_cout;

  // Register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_wready;

  modport master (
    output ex_valid, ex_result, ex_accum_write, ex_reg_write, ex_reg_addr,
           ex_z_write, ex_zout, ex_c_write, ex_cout, rf_wready,
    input  ex_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  ex_valid, ex_result, ex_accum_write, ex_reg_write, ex_reg_addr,
           ex_z_write, ex_zout, ex_c_write, ex_cout, rf_wready,
    output ex_ready, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/alu_writeback_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
// One-entry buffer for the pending register-file write plus the retire/ready
// logic of the writeback stage.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ex_valid          ALU result valid
//   in_data/in_addr   result and destination captured on accept
//   in_reg_write      captured op targets the register file
//   rf_wready         register file takes the write this cycle
//   ex_ready          stage can accept (EMPTY or retiring this cycle)
//   accept            ex_valid && ex_ready
//   slot_full         slot FSM is FULL
//   slot_reg_write    held op is a register write
//   slot_addr/data    held destination address / data
// -----------------------------------------------------------------------------
module wb_slot
  import alu_writeback_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_reg_write,
  input  logic              rf_wready,
  output logic              ex_ready,
  output logic              accept,
  output logic              slot_full,
  output logic              slot_reg_write,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              reg_write_q, reg_write_d;
  logic              retire_s;

  // Non-register ops retire unconditionally; register ops wait for rf_wready.
  // ex_ready depends only on slot state and rf_wready, never on ex_valid.
  assign retire_s       = (state_q == SLOT_FULL) && (!reg_write_q || rf_wready);
  assign ex_ready       = (state_q == SLOT_EMPTY) || retire_s;
  assign accept         = ex_valid && ex_ready;
  assign slot_full      = (state_q == SLOT_FULL);
  assign slot_reg_write = reg_write_q;
  assign slot_addr      = addr_q;
  assign slot_data      = data_q;

  // Next-state and capture logic for the one-entry slot.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    addr_d      = addr_q;
    reg_write_d = reg_write_q;

    case (state_q)
      SLOT_EMPTY: begin
        if (accept) begin
          state_d = SLOT_FULL;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (accept) begin
          state_d = SLOT_FULL;   // retire and reload on the same edge
        end else if (retire_s) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_FULL;   // held: address/data stay stable
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase

    if (accept) begin
      data_d      = in_data;
      addr_d      = in_addr;
      reg_write_d = in_reg_write;
    end else begin
      data_d      = data_q;
      addr_d      = addr_q;
      reg_write_d = reg_write_q;
    end
  end

  // Slot registers; reset discards any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SLOT_EMPTY;
      data_q      <= {DATA_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      reg_write_q <= reg_write_d;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
// Execute/writeback stage behind the ALU. Commits accumulator and Z/C flags on
// accept (visible to the next ALU op with no bubble), buffers one register-file
// write in wb_slot, and resolves read-after-write hazards against that slot.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   wb             alu_writeback_if.slave: ex_* handshake, rf_* write port
//   accum          architectural accumulator (to ALU)
//   flag_z/flag_c  zero / carry flags (flag_c feeds ALU cin)
//   rd_addr        address being read by decode
//   rd_data        raw register-file read data
//   rd_data_fwd    hazard-resolved read data
//   hazard_stall   decode must hold
// Configuration macro: WB_BYPASS_EN
//   defined   -> slot data is forwarded on a hit, hazard_stall stays 0
//   undefined -> raw read data passes through, hazard_stall = hit
// -----------------------------------------------------------------------------
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] ACCUM_RST = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  alu_writeback_if.slave    wb,
  output logic [DATA_W-1:0] accum,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_data_fwd,
  output logic              hazard_stall
);

  logic [DATA_W-1:0] accum_q, accum_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;

  logic              accept_s;
  logic              slot_full_s;
  logic              slot_reg_write_s;
  logic [ADDR_W-1:0] slot_addr_s;
  logic [DATA_W-1:0] slot_data_s;
  logic              hit_s;

  wb_slot #(
    .ADDR_W (ADDR_W)
  ) u_slot (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (wb.ex_valid),
    .in_data        (wb.ex_result),
    .in_addr        (wb.ex_reg_addr),
    .in_reg_write   (wb.ex_reg_write),
    .rf_wready      (wb.rf_wready),
    .ex_ready       (wb.ex_ready),
    .accept         (accept_s),
    .slot_full      (slot_full_s),
    .slot_reg_write (slot_reg_write_s),
    .slot_addr      (slot_addr_s),
    .slot_data      (slot_data_s)
  );

  assign wb.rf_we    = slot_full_s && slot_reg_write_s;
  assign wb.rf_waddr = slot_addr_s;
  assign wb.rf_wdata = slot_data_s;

  assign accum  = accum_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;

  // Accumulator and flags commit at accept, independent of the slot draining,
  // so a stalled register write never delays an already accepted flag update.
  always_comb begin
    accum_d  = accum_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (accept_s) begin
      if (wb.ex_accum_write) begin
        accum_d = wb.ex_result;
      end else begin
        accum_d = accum_q;
      end
      if (wb.ex_z_write) begin
        flag_z_d = wb.ex_zout;
      end else begin
        flag_z_d = flag_z_q;
      end
      if (wb.ex_c_write) begin
        flag_c_d = wb.ex_cout;
      end else begin
        flag_c_d = flag_c_q;
      end
    end else begin
      accum_d  = accum_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
    end
  end

  // Architectural accumulator and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accum_q  <= ACCUM_RST;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      accum_q  <= accum_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // A read hits when the pending register write targets the same address.
  assign hit_s = slot_full_s && slot_reg_write_s && (slot_addr_s == rd_addr);

`ifdef WB_BYPASS_EN
  assign rd_data_fwd  = fwd_select(hit_s, slot_data_s, rd_data);
  assign hazard_stall = 1'b0;
`else
  assign rd_data_fwd  = fwd_select(1'b0, slot_data_s, rd_data);
  assign hazard_stall = hit_s;
`endif

endmodule
